// File: rtl/cp0_timer_intc_pkg.sv
// Shared CP0 timer/interrupt definitions: default parameters, TI routing and Count type.
package cp0_timer_intc_pkg;

    localparam int unsigned DEF_N_EXT_INT   = 6;
    localparam int unsigned DEF_COUNT_W     = 32;
    localparam int unsigned DEF_DIV         = 1;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Timer interrupt is ORed onto the highest hardware IP line
    localparam int unsigned TI_IDX = DEF_N_EXT_INT - 1;

    // Prescaler must hold DIV-1 for DIV up to 16
    localparam int unsigned PRESC_W = 4;

    typedef logic [DEF_COUNT_W-1:0] count_t;

endpackage

// File: rtl/cp0_timer_intc_sync_chain.sv
// Multi-bit flop chain synchroniser; STAGES=0 degenerates to a wire.
module cp0_timer_intc_sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES == 0) begin : g_bypass
        assign q = d;
    end else begin : g_chain
        logic [WIDTH-1:0] stage [STAGES];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < int'(STAGES); i++) stage[i] <= '0;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[STAGES-1];
    end

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with Cause.TI, external interrupt synchronisation
// and the masked interrupt request sampled by the core at commit.
module cp0_timer_intc
    import cp0_timer_intc_pkg::*;
#(
    parameter int unsigned N_EXT_INT   = DEF_N_EXT_INT,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter int unsigned DIV         = DEF_DIV,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_EXT_INT-1:0] ext_int,
    input  logic                 count_we,
    input  logic                 compare_we,
    input  logic [COUNT_W-1:0]   wdata,
    input  logic                 status_ie,
    input  logic                 status_exl,
    input  logic [N_EXT_INT+1:0] status_im,
    input  logic [1:0]           cause_ip_sw,
    output logic [COUNT_W-1:0]   count,
    output logic [COUNT_W-1:0]   compare,
    output logic                 ti,
    output logic [N_EXT_INT-1:0] ip_hw,
    output logic                 irq
);

    localparam int unsigned TI_BIT = N_EXT_INT - 1;

    logic [PRESC_W-1:0]   presc;
    logic                 tick;
    logic [COUNT_W-1:0]   count_inc;
    logic                 ti_set;
    logic [N_EXT_INT-1:0] ext_sync;

    assign tick      = (presc == PRESC_W'(DIV - 1));
    assign count_inc = count + COUNT_W'(1);
    // Only a tick-driven increment can raise TI; an MTC0 Count write never does
    assign ti_set    = tick && !count_we && (count_inc == compare);

    // Prescaler restarts on a Count write so the next tick is a full DIV period away
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (count_we || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
            end else if (tick) begin
                count <= count_inc;
            end

            if (compare_we) begin
                compare <= wdata;
            end

            // Compare write wins over a same-cycle match; TI is otherwise sticky
            if (compare_we) begin
                ti <= 1'b0;
            end else if (ti_set) begin
                ti <= 1'b1;
            end
        end
    end

    cp0_timer_intc_sync_chain #(
        .WIDTH  (N_EXT_INT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_int),
        .q      (ext_sync)
    );

    assign ip_hw = ext_sync | (N_EXT_INT'(ti) << TI_BIT);
    assign irq   = status_ie && !status_exl && (|({ip_hw, cause_ip_sw} & status_im));

endmodule
